// File: rtl/sd_emmc_axi_burst_slave.sv
// sd_emmc_axi_burst_slave
//   AXI4 INCR burst responder for the SD/eMMC DMA master. The DMA writes
//   bursts into an on-chip word buffer and reads bursts back from it.
//   Transfers are 32-bit beats. The word index is addr[MEM_AW+1:2] and
//   wraps silently inside the buffer.
//
// Optional feature:
//   SD_EMMC_SLV_WSTRB_EN - when defined, each byte lane is written only if
//   its s_wstrb bit is set. When undefined, s_wstrb is ignored and every
//   accepted beat writes the full word.
//
// Ports:
//   clock, reset                   clock; asynchronous active-low reset
//   s_aw*                          write address channel (addr, len, valid/ready)
//   s_w*                           write data channel (data, strb, last, valid/ready)
//   s_b*                           write response channel (resp, valid/ready)
//   s_ar*                          read address channel (addr, len, valid/ready)
//   s_r*                           read data channel (data, resp, last, valid/ready)
module sd_emmc_axi_burst_slave #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          MEM_AW    = 9,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready
);

  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [31:0] r_mem [DEPTH];

  // ---------------- write side ----------------
  wstate_t           r_wstate, w_wstate_nx;
  logic              r_awready, r_wready, r_bvalid;
  logic [1:0]        r_bresp;
  logic [MEM_AW-1:0] r_wptr;
  logic [7:0]        r_wlen, r_wcnt;
  logic              r_win;
  logic              w_aw_hs, w_w_beat, w_w_end, w_b_done, w_aw_win;

  assign w_aw_win = (s_awaddr[ADDR_W-1:MEM_AW+2] == BASE_ADDR[ADDR_W-1:MEM_AW+2]);
  assign w_aw_hs  = (r_wstate == W_IDLE) && s_awvalid && r_awready;
  assign w_w_beat = (r_wstate == W_DATA) && s_wvalid && r_wready;
  assign w_w_end  = w_w_beat && ((r_wcnt == r_wlen) || s_wlast);
  assign w_b_done = (r_wstate == W_RESP) && r_bvalid && s_bready;

  always_comb begin
    w_wstate_nx = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs)  w_wstate_nx = W_DATA;
      W_DATA:  if (w_w_end)  w_wstate_nx = W_RESP;
      W_RESP:  if (w_b_done) w_wstate_nx = W_IDLE;
      default: w_wstate_nx = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so that every
  // output reads 0 while reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_wptr    <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_win     <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nx;
      r_awready <= (w_wstate_nx == W_IDLE);
      r_wready  <= (w_wstate_nx == W_DATA);
      r_bvalid  <= (w_wstate_nx == W_RESP);
      if (w_aw_hs) begin
        r_wptr <= s_awaddr[MEM_AW+1:2];
        r_wlen <= s_awlen;
        r_wcnt <= '0;
        r_win  <= w_aw_win;
      end
      if (w_w_beat) begin
        r_wptr <= r_wptr + MEM_AW'(1);
        r_wcnt <= r_wcnt + 8'd1;
      end
      // Error when out of window or wlast disagrees with the beat count.
      if (w_w_end)
        r_bresp <= (!r_win || (s_wlast != (r_wcnt == r_wlen))) ? SLVERR : OKAY;
      else if (w_b_done)
        r_bresp <= OKAY;
    end
  end

  // Buffer is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_w_beat && r_win) begin
`ifdef SD_EMMC_SLV_WSTRB_EN
      for (int unsigned b = 0; b < 4; b++)
        if (s_wstrb[b]) r_mem[r_wptr][8*b +: 8] <= s_wdata[8*b +: 8];
`else
      r_mem[r_wptr] <= s_wdata;
`endif
    end
  end

  // ---------------- read side ----------------
  rstate_t           r_rstate, w_rstate_nx;
  logic              r_arready, r_rvalid, r_rlast, r_rwin;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;
  logic [MEM_AW-1:0] r_rptr, w_rptr_nx, w_ar_idx;
  logic [7:0]        r_rlen, r_rcnt;
  logic              w_ar_hs, w_r_hs, w_ar_win;

  assign w_ar_win  = (s_araddr[ADDR_W-1:MEM_AW+2] == BASE_ADDR[ADDR_W-1:MEM_AW+2]);
  assign w_ar_idx  = s_araddr[MEM_AW+1:2];
  assign w_rptr_nx = r_rptr + MEM_AW'(1);
  assign w_ar_hs   = (r_rstate == R_IDLE) && s_arvalid && r_arready;
  assign w_r_hs    = (r_rstate == R_DATA) && r_rvalid && s_rready;

  always_comb begin
    w_rstate_nx = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)           w_rstate_nx = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nx = R_IDLE;
      default: w_rstate_nx = R_IDLE;
    endcase
  end

  // Registered read port: a same-cycle write to the word being read is not
  // visible, so the read returns the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= '0;
      r_rdata   <= '0;
      r_rwin    <= 1'b0;
      r_rptr    <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
    end else begin
      r_rstate  <= w_rstate_nx;
      r_arready <= (w_rstate_nx == R_IDLE);
      if (w_ar_hs) begin
        r_rptr   <= w_ar_idx;
        r_rwin   <= w_ar_win;
        r_rlen   <= s_arlen;
        r_rcnt   <= '0;
        r_rvalid <= 1'b1;
        r_rlast  <= (s_arlen == 8'd0);
        r_rresp  <= w_ar_win ? OKAY : SLVERR;
        r_rdata  <= w_ar_win ? r_mem[w_ar_idx] : '0;
      end else if (w_r_hs) begin
        if (r_rlast) begin
          r_rvalid <= 1'b0;
          r_rlast  <= 1'b0;
          r_rresp  <= OKAY;
        end else begin
          r_rptr  <= w_rptr_nx;
          r_rcnt  <= r_rcnt + 8'd1;
          r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
          r_rdata <= r_rwin ? r_mem[w_rptr_nx] : '0;
        end
      end
    end
  end

  logic w_unused;
`ifdef SD_EMMC_SLV_WSTRB_EN
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0], s_wstrb};
`endif

  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rlast   = r_rlast;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;

endmodule

// File: tb/tb_sd_emmc_axi_burst_slave.sv
// Self-checking bench for sd_emmc_axi_burst_slave (default parameters:
// 2 KB window at base 0). Burst-level vector table plus hand-written
// sequences for byte strobes and reset in mid-burst.
module tb_sd_emmc_axi_burst_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0;
  logic [7:0]  s_awlen = '0, s_arlen = '0;
  logic        s_awvalid = 1'b0, s_wlast = 1'b0, s_wvalid = 1'b0;
  logic        s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic [3:0]  s_wstrb = 4'hF;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rlast, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  always #5 clock = ~clock;

  sd_emmc_axi_burst_slave #(.ADDR_W(32), .MEM_AW(9), .BASE_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready)
  );

`ifdef SD_EMMC_SLV_WSTRB_EN
  localparam logic [3:0] STRB_FORCE = 4'h0;
`else
  localparam logic [3:0] STRB_FORCE = 4'hF;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [512];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          len;
    int          wlast_at;   // beat carrying wlast, -1 = never
    logic [31:0] dbase;
    bit          toggle;     // read: rready alternates 0/1
    logic [1:0]  exp_resp;
    int          exp_beats;  // write: beats accepted before bvalid
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  function automatic bit in_win(input logic [31:0] addr);
    return addr[31:11] == 21'd0;
  endfunction

  task automatic model_write(input logic [8:0] idx, input logic [31:0] d, input logic [3:0] strb);
    logic [3:0] m;
    m = strb | STRB_FORCE;
    for (int b = 0; b < 4; b++)
      if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int wlast_at,
                          input logic [31:0] dbase, input logic [3:0] strb,
                          output int beats, output logic [1:0] resp);
    bit got;
    int gaps;
    logic [8:0] idx;
    beats = 0;
    resp  = 2'b11;
    gaps  = 0;
    s_awaddr = addr; s_awlen = 8'(len); s_awvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      if (s_awready) got = 1'b1;
      @(posedge clock); #1;
    end
    s_awvalid = 1'b0;
    if (!got) begin fail_now("aw_handshake"); return; end
    s_wvalid = 1'b1; s_wstrb = strb; s_wdata = dbase; s_wlast = (wlast_at == 0);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clock);
      if (s_bvalid) got = 1'b1;
      else begin
        if (s_wready) begin
          idx = 9'(addr[10:2] + 9'(beats));
          if (in_win(addr)) model_write(idx, s_wdata, strb);
          beats++;
        end else gaps++;
        @(posedge clock); #1;
        s_wdata = dbase + 32'(beats);
        s_wlast = (wlast_at == beats);
      end
    end
    s_wvalid = 1'b0; s_wlast = 1'b0; s_wstrb = 4'hF;
    check("wready_gaps", 32'(gaps), 32'd0);
    if (!got) begin fail_now("bvalid_wait"); return; end
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clock); #1;
    s_bready = 1'b0;
    @(negedge clock);
    check("bvalid_clear", 32'(s_bvalid), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input bit toggle,
                         input logic [1:0] exp_resp, input int vi);
    bit got, held;
    int beat;
    logic [31:0] h_data, exp;
    logic [1:0] h_resp;
    logic h_last;
    logic [8:0] idx;
    s_araddr = addr; s_arlen = 8'(len); s_arvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      if (s_arready) begin
        got = 1'b1;
        check($sformatf("v%0d_rvalid_idle", vi), 32'(s_rvalid), 32'd0);
      end
      @(posedge clock); #1;
    end
    s_arvalid = 1'b0;
    if (!got) begin fail_now("ar_handshake"); return; end
    beat = 0; held = 1'b0;
    h_data = '0; h_resp = '0; h_last = 1'b0;
    for (int c = 0; beat <= len && c < 200; c++) begin
      s_rready = toggle ? (c % 2 == 1) : 1'b1;
      @(negedge clock);
      if (c == 0) check($sformatf("v%0d_first_rvalid", vi), 32'(s_rvalid), 32'd1);
      if (s_rvalid) begin
        if (held) begin
          check($sformatf("v%0d_stall_rdata", vi), s_rdata, h_data);
          check($sformatf("v%0d_stall_rlast", vi), 32'(s_rlast), 32'(h_last));
          check($sformatf("v%0d_stall_rresp", vi), 32'(s_rresp), 32'(h_resp));
        end
        if (s_rready) begin
          idx = 9'(addr[10:2] + 9'(beat));
          exp = in_win(addr) ? model[idx] : 32'd0;
          check($sformatf("v%0d_rdata_b%0d", vi, beat), s_rdata, exp);
          check($sformatf("v%0d_rresp_b%0d", vi, beat), 32'(s_rresp), 32'(exp_resp));
          check($sformatf("v%0d_rlast_b%0d", vi, beat), 32'(s_rlast), 32'(beat == len));
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1; h_data = s_rdata; h_last = s_rlast; h_resp = s_rresp;
        end
      end
      @(posedge clock); #1;
    end
    if (beat <= len) fail_now($sformatf("v%0d_read_beats", vi));
    s_rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check($sformatf("v%0d_rvalid_after", vi), 32'({s_rvalid, s_rlast}), 32'd0);
      @(posedge clock); #1;
    end
    s_rready = 1'b0;
  endtask

  initial begin
    int beats;
    logic [1:0] resp;
    bit got;

    //          wr addr          len wl  dbase         tog resp   beats
    vecs[0]  = '{1, 32'h0000_0040, 15, 15, 32'h0000_0000, 0, 2'b00, 16};
    vecs[1]  = '{0, 32'h0000_0040, 15, -1, 32'h0,         0, 2'b00, 0};
    vecs[2]  = '{0, 32'h0000_0040, 15, -1, 32'h0,         1, 2'b00, 0};
    vecs[3]  = '{1, 32'h0000_0000,  3,  3, 32'h0000_0100, 0, 2'b00, 4};
    vecs[4]  = '{1, 32'h0000_1000,  3,  3, 32'h0000_00A0, 0, 2'b10, 4};
    vecs[5]  = '{0, 32'h0000_0000,  3, -1, 32'h0,         0, 2'b00, 0};
    vecs[6]  = '{0, 32'h0000_1000,  3, -1, 32'h0,         1, 2'b10, 0};
    vecs[7]  = '{1, 32'h0000_0080, 15,  7, 32'h0000_0200, 0, 2'b10, 8};
    vecs[8]  = '{1, 32'h0000_00C0,  3, -1, 32'h0000_0300, 0, 2'b10, 4};
    vecs[9]  = '{0, 32'h0000_0080,  7, -1, 32'h0,         0, 2'b00, 0};
    vecs[10] = '{0, 32'h0000_00C0,  3, -1, 32'h0,         0, 2'b00, 0};
    vecs[11] = '{1, 32'h0000_07F8,  3,  3, 32'h0000_0400, 0, 2'b00, 4};
    vecs[12] = '{0, 32'h0000_07F8,  3, -1, 32'h0,         0, 2'b00, 0};
    vecs[13] = '{0, 32'h0000_0000,  1, -1, 32'h0,         0, 2'b00, 0};
    vecs[14] = '{1, 32'h0000_0100,  0,  0, 32'h0000_0055, 0, 2'b00, 1};
    vecs[15] = '{0, 32'h0000_0100,  0, -1, 32'h0,         0, 2'b00, 0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_ctrl", 32'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rlast, s_rresp}), 32'd0);
    check("reset_rdata", s_rdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].len, vecs[i].wlast_at, vecs[i].dbase, 4'hF, beats, resp);
        check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_wbeats", i), 32'(beats), 32'(vecs[i].exp_beats));
      end else begin
        do_read(vecs[i].addr, vecs[i].len, vecs[i].toggle, vecs[i].exp_resp, i);
      end
    end

    // Byte strobes: with the feature only the low two lanes change.
    do_write(32'h0000_0200, 0, 0, 32'h1234_5678, 4'hF, beats, resp);
    check("strb_init_bresp", 32'(resp), 32'd0);
    do_write(32'h0000_0200, 0, 0, 32'hFFFF_FFFF, 4'b0011, beats, resp);
    check("strb_bresp", 32'(resp), 32'd0);
    do_read(32'h0000_0200, 0, 1'b0, 2'b00, 100);

    // Reset asserted while beat 5 of a write burst is being presented.
    s_awaddr = 32'h0000_0300; s_awlen = 8'd15; s_awvalid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clock);
      if (s_awready) got = 1'b1;
      @(posedge clock); #1;
    end
    s_awvalid = 1'b0;
    if (!got) fail_now("rst_aw_handshake");
    s_wvalid = 1'b1; s_wstrb = 4'hF;
    for (int k = 0; k < 5; k++) begin
      s_wdata = 32'h900 + 32'(k);
      @(negedge clock);
      check($sformatf("rst_wready_b%0d", k), 32'(s_wready), 32'd1);
      if (s_wready) model_write(9'(192 + k), s_wdata, 4'hF);
      @(posedge clock); #1;
    end
    s_wdata = 32'h905;
    #2 reset = 1'b0;
    #1;
    check("midrst_ctrl", 32'({s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rlast, s_rresp}), 32'd0);
    check("midrst_rdata", s_rdata, 32'd0);
    s_wvalid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    do_write(32'h0000_0340, 3, 3, 32'h0000_0A00, 4'hF, beats, resp);
    check("post_rst_bresp", 32'(resp), 32'd0);
    check("post_rst_wbeats", 32'(beats), 32'd4);
    do_read(32'h0000_0340, 3, 1'b0, 2'b00, 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
